cd_tx_ctrl: RTL and testbench

Transmit scheduler sitting directly downstream of the CDBUS CSR block and upstream of the byte serializer. It takes the two-page TX buffer handshake (`tx_ram_switch`, `tx_abort`, `has_break`) and the timing settings, tracks bus idle time in bit periods, and decides when a frame or break may start. It returns `tx_pending`, `bus_idle`, `cd`, `tx_err` and `ack_break` to the CSR block.

---
 rtl/cd_tx_ctrl_if.sv | 32 +++
 rtl/cd_tx_ctrl.sv | 155 +++++++++++++++
 tb/tb_cd_tx_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cd_tx_ctrl_if.sv
// cd_tx_ctrl_if: handshake bundle between the CSR block / serializer side
// (master) and the transmit scheduler (slave).
//   settings : full_duplex, arbitration, idle_wait_len, tx_permit_len, tx_pre_len
//   line     : bit_tick, rxd in; drive_en, drive_val out
//   CSR      : tx_ram_switch, tx_abort, has_break in;
//              bus_idle, tx_pending, cd, tx_err, ack_break out
//   serializer: tx_done, tx_collision in; tx_page, tx_start, tx_stop out
interface cd_tx_ctrl_if;
  logic       bit_tick, rxd, full_duplex, arbitration;
  logic [7:0] idle_wait_len;
  logic [9:0] tx_permit_len;
  logic [1:0] tx_pre_len;
  logic       tx_ram_switch, tx_abort, has_break, tx_done, tx_collision;
  logic       bus_idle, tx_pending, tx_page, tx_start, tx_stop;
  logic       drive_en, drive_val, cd, tx_err, ack_break;

  modport master (
    output bit_tick, rxd, full_duplex, arbitration, idle_wait_len,
           tx_permit_len, tx_pre_len, tx_ram_switch, tx_abort, has_break,
           tx_done, tx_collision,
    input  bus_idle, tx_pending, tx_page, tx_start, tx_stop, drive_en,
           drive_val, cd, tx_err, ack_break
  );

  modport slave (
    input  bit_tick, rxd, full_duplex, arbitration, idle_wait_len,
           tx_permit_len, tx_pre_len, tx_ram_switch, tx_abort, has_break,
           tx_done, tx_collision,
    output bus_idle, tx_pending, tx_page, tx_start, tx_stop, drive_en,
           drive_val, cd, tx_err, ack_break
  );
endinterface

// File: rtl/cd_tx_ctrl.sv
// cd_tx_ctrl: CDBUS transmit scheduler. Tracks bus idle time in bit periods,
// manages the two-page TX handover and sequences break / preamble / frame.
// Ports: clk, reset (sync, active-high), bus (cd_tx_ctrl_if.slave).
// All outputs are registered; event outputs are single-cycle pulses.
module cd_tx_ctrl #(
  parameter int BRK_BITS = 12
) (
  input logic         clk,
  input logic         reset,
  cd_tx_ctrl_if.slave bus
);
  localparam int BW = $clog2(BRK_BITS + 1);
  localparam logic [BW-1:0] BRK_LAST = BW'(BRK_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PERMIT, S_PREAMBLE, S_SEND, S_BREAK
  } state_t;

  state_t        state;
  logic [9:0]    idle_cnt, idle_cnt_nxt;
  logic          permit_ok, write_page, done_now;
  logic [1:0]    pre_cnt;
  logic [BW-1:0] brk_cnt;

  // Next idle count; the registered compares use it so that bus_idle and
  // permit drop the cycle after rxd goes low (no stale permit after a
  // collision).
  always_comb begin
    idle_cnt_nxt = idle_cnt;
    if (!bus.rxd)
      idle_cnt_nxt = '0;
    else if (bus.bit_tick && idle_cnt != 10'd1023)
      idle_cnt_nxt = idle_cnt + 10'd1;
  end

  // A finishing frame frees the pending slot in the same cycle, so a
  // coincident page switch is accepted.
  assign done_now = (state == S_SEND) && bus.tx_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      idle_cnt       <= '0;
      permit_ok      <= 1'b0;
      write_page     <= 1'b0;
      pre_cnt        <= '0;
      brk_cnt        <= '0;
      bus.bus_idle   <= 1'b0;
      bus.tx_pending <= 1'b0;
      bus.tx_page    <= 1'b0;
      bus.tx_start   <= 1'b0;
      bus.tx_stop    <= 1'b0;
      bus.drive_en   <= 1'b0;
      bus.drive_val  <= 1'b0;
      bus.cd         <= 1'b0;
      bus.tx_err     <= 1'b0;
      bus.ack_break  <= 1'b0;
    end else begin
      idle_cnt      <= idle_cnt_nxt;
      bus.bus_idle  <= (idle_cnt_nxt >= {2'b00, bus.idle_wait_len});
      permit_ok     <= (idle_cnt_nxt >= bus.tx_permit_len);
      bus.tx_start  <= 1'b0;
      bus.tx_stop   <= 1'b0;
      bus.cd        <= 1'b0;
      bus.tx_err    <= 1'b0;
      bus.ack_break <= 1'b0;

      case (state)
        S_IDLE: begin
          // has_break is still high while ack_break is out; don't re-enter.
          if (bus.has_break && !bus.ack_break && (bus.bus_idle || bus.full_duplex)) begin
            state         <= S_BREAK;
            brk_cnt       <= '0;
            bus.drive_en  <= 1'b1;
            bus.drive_val <= 1'b0;
          end else if (bus.tx_pending) begin
            state <= S_WAIT_PERMIT;
          end
        end
        S_WAIT_PERMIT: begin
          if (bus.tx_abort) begin
            state          <= S_IDLE;
            bus.tx_pending <= 1'b0;
          end else if (bus.full_duplex || permit_ok) begin
            if (bus.tx_pre_len != 2'd0) begin
              state         <= S_PREAMBLE;
              pre_cnt       <= '0;
              bus.drive_en  <= 1'b1;
              bus.drive_val <= 1'b1;
            end else begin
              state        <= S_SEND;
              bus.tx_start <= 1'b1;
            end
          end
        end
        S_PREAMBLE: begin
          if (bus.tx_abort) begin
            state          <= S_IDLE;
            bus.tx_pending <= 1'b0;
            bus.drive_en   <= 1'b0;
            bus.drive_val  <= 1'b0;
          end else if (bus.bit_tick) begin
            if ({1'b0, pre_cnt} + 3'd1 == {1'b0, bus.tx_pre_len}) begin
              state         <= S_SEND;
              bus.tx_start  <= 1'b1;
              bus.drive_en  <= 1'b0;
              bus.drive_val <= 1'b0;
            end else begin
              pre_cnt <= pre_cnt + 2'd1;
            end
          end
        end
        S_SEND: begin
          if (bus.tx_done) begin
            state          <= S_IDLE;
            bus.tx_pending <= 1'b0;
          end else if (bus.tx_abort) begin
            state          <= S_IDLE;
            bus.tx_pending <= 1'b0;
            bus.tx_stop    <= 1'b1;
          end else if (bus.tx_collision && !bus.full_duplex) begin
            bus.tx_stop <= 1'b1;
            bus.cd      <= 1'b1;
            if (bus.arbitration) begin
              state <= S_WAIT_PERMIT;      // lost arbitration: retry same page
            end else begin
              state          <= S_IDLE;
              bus.tx_err     <= 1'b1;
              bus.tx_pending <= 1'b0;
            end
          end
        end
        S_BREAK: begin
          if (bus.bit_tick) begin
            if (brk_cnt == BRK_LAST) begin
              state         <= S_IDLE;
              bus.ack_break <= 1'b1;
              bus.drive_en  <= 1'b0;
            end else begin
              brk_cnt <= brk_cnt + BW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Page handover; placed last so it overrides a same-cycle clear.
      if (bus.tx_ram_switch && (!bus.tx_pending || done_now)) begin
        bus.tx_pending <= 1'b1;
        bus.tx_page    <= write_page;
        write_page     <= ~write_page;
      end
    end
  end
endmodule

// File: tb/tb_cd_tx_ctrl.sv
module tb_cd_tx_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cd_tx_ctrl_if bus();
  cd_tx_ctrl #(.BRK_BITS(12)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0, errors = 0;
  int div = 0, nticks = 0;
  bit auto_tick = 1'b1;

  typedef struct {
    logic rxd;
    logic tick;
    logic exp_idle;
  } vec_t;
  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; bit_tick every 4th cycle when auto_tick. Sample #1 after edge.
  task automatic step();
    if (auto_tick) begin
      bus.bit_tick = (div == 0);
      div = (div + 1) % 4;
    end
    @(posedge clk); #1;
    if (bus.bit_tick && bus.rxd) nticks++;
  endtask

  task automatic cfg(input bit fd, input bit arb, input int wl, input int pl, input int pre);
    bus.full_duplex   = fd;
    bus.arbitration   = arb;
    bus.idle_wait_len = 8'(wl);
    bus.tx_permit_len = 10'(pl);
    bus.tx_pre_len    = 2'(pre);
  endtask

  task automatic do_reset();
    bus.rxd = 1'b1; bus.bit_tick = 1'b0; bus.tx_ram_switch = 1'b0;
    bus.tx_abort = 1'b0; bus.has_break = 1'b0; bus.tx_done = 1'b0;
    bus.tx_collision = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    div = 0; nticks = 0;
  endtask

  task automatic pulse_switch();
    bus.tx_ram_switch = 1'b1; step(); bus.tx_ram_switch = 1'b0;
  endtask

  task automatic wait_start(input string name, input int max);
    int n = 0;
    while (!bus.tx_start && n < max) begin step(); n++; end
    chk(name, bus.tx_start, 1);
  endtask

  initial begin
    int n, bt, ok;
    int mcnt, mwait;
    bit mpend, mpage, mwp;

    // ---------------- reset state ----------------
    cfg(0, 0, 0, 0, 0);
    do_reset();
    chk("rst bus_idle", bus.bus_idle, 0);
    chk("rst tx_pending", bus.tx_pending, 0);
    chk("rst tx_page", bus.tx_page, 0);
    chk("rst pulses", {bus.tx_start, bus.tx_stop, bus.cd, bus.tx_err, bus.ack_break}, 0);
    chk("rst drive", {bus.drive_en, bus.drive_val}, 0);

    // ---------------- table: idle counter / bus_idle, wait_len=3 ----------------
    vt[0]  = '{1'b1, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 1'b0};
    vt[10] = '{1'b1, 1'b1, 1'b1};
    cfg(0, 0, 3, 1023, 0);
    do_reset();
    auto_tick = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.rxd = vt[i].rxd;
      bus.bit_tick = vt[i].tick;
      step();
      chk($sformatf("vec%0d bus_idle", i), bus.bus_idle, vt[i].exp_idle);
    end
    bus.bit_tick = 1'b0; bus.rxd = 1'b1;
    auto_tick = 1'b1;

    // ---------------- full duplex latency, abort+done ----------------
    cfg(1, 0, 10, 20, 0);
    do_reset();
    pulse_switch();
    chk("fd pending rise", bus.tx_pending, 1);
    n = 1;
    while (!bus.tx_start && n < 10) begin step(); n++; end
    chk("fd start latency", n, 3);
    bus.tx_done = 1'b1; bus.tx_abort = 1'b1; step();
    bus.tx_done = 1'b0; bus.tx_abort = 1'b0;
    chk("done+abort no stop", bus.tx_stop, 0);
    chk("done+abort pending", bus.tx_pending, 0);

    // ---------------- double switch, done+switch ----------------
    do_reset();
    pulse_switch();
    for (int i = 0; i < 4; i++) step();
    pulse_switch();
    chk("2nd switch page", bus.tx_page, 0);
    chk("2nd switch pending", bus.tx_pending, 1);
    bus.tx_done = 1'b1; bus.tx_ram_switch = 1'b1; step();
    bus.tx_done = 1'b0; bus.tx_ram_switch = 1'b0;
    chk("done+switch pending", bus.tx_pending, 1);
    chk("done+switch page", bus.tx_page, 1);
    wait_start("done+switch restart", 6);
    // reset mid-frame: no tx_stop, back to reset state
    reset = 1'b1; step(); reset = 1'b0;
    chk("midreset stop", bus.tx_stop, 0);
    chk("midreset pending", bus.tx_pending, 0);
    chk("midreset page", bus.tx_page, 0);

    // ---------------- half duplex main flow ----------------
    cfg(0, 0, 10, 20, 1);
    do_reset();
    pulse_switch();
    n = 0;
    while (!bus.bus_idle && n < 200) begin step(); n++; end
    chk("hd bus_idle ticks", nticks, 10);
    while (!bus.drive_en && n < 400) begin step(); n++; end
    chk("hd preamble ticks", nticks, 20);
    chk("hd preamble val", bus.drive_val, 1);
    while (!bus.tx_start && n < 400) begin step(); n++; end
    chk("hd start ticks", nticks, 21);
    chk("hd drive off", bus.drive_en, 0);
    bus.tx_done = 1'b1; step(); bus.tx_done = 1'b0;
    chk("hd done pending", bus.tx_pending, 0);

    // ---------------- collision with / without arbitration ----------------
    cfg(0, 1, 10, 20, 0);
    do_reset();
    pulse_switch();
    wait_start("arb first start", 200);
    bus.tx_collision = 1'b1; bus.rxd = 1'b0; step();
    bus.tx_collision = 1'b0; bus.rxd = 1'b1;
    chk("arb cd+stop+err", {bus.cd, bus.tx_stop, bus.tx_err}, 3'b110);
    chk("arb pending kept", bus.tx_pending, 1);
    nticks = 0;
    wait_start("arb retry start", 200);
    chk("arb retry ticks", nticks, 20);
    bus.arbitration = 1'b0;
    bus.tx_collision = 1'b1; bus.rxd = 1'b0; step();
    bus.tx_collision = 1'b0; bus.rxd = 1'b1;
    chk("noarb cd+stop+err", {bus.cd, bus.tx_stop, bus.tx_err}, 3'b111);
    chk("noarb pending", bus.tx_pending, 0);
    step();
    chk("noarb err 1 cycle", bus.tx_err, 0);

    // ---------------- break priority over pending data ----------------
    cfg(0, 0, 10, 20, 0);
    do_reset();
    n = 0;
    while (nticks < 12 && n < 200) begin step(); n++; end
    bus.has_break = 1'b1;
    pulse_switch();
    chk("brk entry drive", {bus.drive_en, bus.drive_val}, 2'b10);
    bus.rxd = 1'b0;
    bt = 0; ok = 1; n = 0;
    while (!bus.ack_break && n < 200) begin
      if (!(bus.drive_en && !bus.drive_val)) ok = 0;
      step();
      if (bus.bit_tick) bt++;
      n++;
    end
    bus.has_break = 1'b0; bus.rxd = 1'b1;
    chk("brk ack", bus.ack_break, 1);
    chk("brk ticks", bt, 12);
    chk("brk line low", ok, 1);
    chk("brk pending kept", bus.tx_pending, 1);
    step();
    chk("brk ack 1 cycle", bus.ack_break, 0);
    wait_start("brk then data", 300);

    // ---------------- rxd low mid-permit, abort in PREAMBLE ----------------
    cfg(0, 0, 10, 20, 2);
    do_reset();
    pulse_switch();
    n = 0;
    while (nticks < 10 && n < 200) begin step(); n++; end
    bus.rxd = 1'b0; step(); bus.rxd = 1'b1;
    nticks = 0; n = 0;
    while (!bus.drive_en && n < 300) begin step(); n++; end
    chk("permit restart ticks", nticks, 20);
    step();
    bus.tx_abort = 1'b1; step(); bus.tx_abort = 1'b0;
    chk("pre abort pending", bus.tx_pending, 0);
    chk("pre abort drive", bus.drive_en, 0);
    chk("pre abort stop", bus.tx_stop, 0);

    // ---------------- abort in WAIT_PERMIT and SEND ----------------
    do_reset();
    pulse_switch();
    step(); step();
    bus.tx_abort = 1'b1; step(); bus.tx_abort = 1'b0;
    chk("wait abort pending", bus.tx_pending, 0);
    chk("wait abort stop", bus.tx_stop, 0);
    cfg(1, 0, 10, 20, 0);
    do_reset();
    pulse_switch();
    wait_start("send abort start", 10);
    bus.tx_abort = 1'b1; step(); bus.tx_abort = 1'b0;
    chk("send abort stop", bus.tx_stop, 1);
    chk("send abort pending", bus.tx_pending, 0);

    // ---------------- randomized: idle counter, bus_idle, page handover ----------------
    cfg(0, 0, 5, 1023, 0);
    do_reset();
    auto_tick = 1'b0;
    mcnt = 0; mwait = 5; mpend = 0; mpage = 0; mwp = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        mwait = int'($urandom_range(0, 47));
        bus.idle_wait_len = 8'(mwait);
      end
      bus.rxd = ($urandom_range(0, 31) != 0);
      bus.bit_tick = $urandom_range(0, 1);
      bus.tx_ram_switch = ($urandom_range(0, 49) == 0);
      if (!bus.rxd) mcnt = 0;
      else if (bus.bit_tick && mcnt < 1023) mcnt++;
      if (bus.tx_ram_switch && !mpend) begin
        mpend = 1; mpage = mwp; mwp = ~mwp;
      end
      step();
      chk("rnd bus_idle", bus.bus_idle, (mcnt >= mwait));
      chk("rnd pending", bus.tx_pending, mpend);
      chk("rnd page", bus.tx_page, mpage);
    end
    bus.tx_ram_switch = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
